bus_uart: RTL

Memory-mapped 8N1 UART peripheral on the 6502 core's system bus, alongside the block RAM. It decodes a 4-byte register window, buffers transmit bytes in a FIFO, and drives a serial TX line. An optional receiver feeds a one-byte holding register. A level-sensitive interrupt goes to the core's IRQ input. Read data follows the same registered one-cycle latency as the RAM, so the top level selects it with `o_hit`.

---
 rtl/bus_uart_if.sv | 12 +
 rtl/bus_uart.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_if.sv
// Core-bus side of the UART window: address/data/direction in, registered read data and hit out.
// The core drives through the master modport; the peripheral responds through the slave modport.
interface bus_uart_if;
    logic [15:0] i_addr;
    logic [7:0]  i_wdata;
    logic        i_rw;
    logic [7:0]  o_rdata;
    logic        o_hit;

    modport master (output i_addr, i_wdata, i_rw, input  o_rdata, o_hit);
    modport slave  (input  i_addr, i_wdata, i_rw, output o_rdata, o_hit);
endinterface

// File: rtl/bus_uart.sv
// 8N1 UART on the 6502 bus: 4-byte register window, TX FIFO + shifter, optional receiver (BUS_UART_RX_EN).
// Latency: read data/hit one cycle after the address; TX line starts the cycle after a FIFO pop.
// Backpressure: none on the bus; a DATA write into a full FIFO is silently dropped.
module bus_uart #(
    parameter logic [15:0] BASE_ADDR    = 16'hD000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic      i_clk,
    input  logic      i_rst,
    bus_uart_if.slave bus,
    output logic      o_irq,
    output logic      o_txd,
    input  logic      i_rxd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic       sel, rd_en, wr_en;
    logic [1:0] off;
    assign sel   = (bus.i_addr[15:2] == BASE_ADDR[15:2]);
    assign off   = bus.i_addr[1:0];
    assign rd_en = sel && bus.i_rw;
    assign wr_en = sel && !bus.i_rw;

    // TX FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          tx_full, tx_empty, push, pop;

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    tx_state_t     tx_state_q, tx_state_d;
    logic [8:0]    tx_sh_q, tx_sh_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [CW-1:0] tx_clk_q, tx_clk_d;
    logic          txd_q, txd_d, tx_busy;

    assign tx_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign tx_empty = (cnt_q == '0);
    assign tx_busy  = (tx_state_q == TX_SHIFT);
    assign push     = wr_en && (off == 2'd0) && !tx_full;
    assign pop      = (tx_state_q == TX_IDLE) && !tx_empty;

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wptr_q] <= bus.i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Shifter holds {stop, data}; the start bit is driven directly at load time.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_clk_d   = tx_clk_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_state_d = TX_SHIFT;
                    tx_sh_d    = {1'b1, fifo_mem[rptr_q]};
                    tx_bit_d   = '0;
                    tx_clk_d   = '0;
                    txd_d      = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (tx_clk_q == BIT_LAST) begin
                    tx_clk_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        txd_d      = 1'b1;
                    end else begin
                        txd_d    = tx_sh_q[0];
                        tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_clk_d = tx_clk_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_clk_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_clk_q   <= tx_clk_d;
            txd_q      <= txd_d;
        end
    end

    logic tx_ie_q;
    always_ff @(posedge i_clk) begin
        if (i_rst)                         tx_ie_q <= 1'b0;
        else if (wr_en && (off == 2'd2))   tx_ie_q <= bus.i_wdata[0];
    end

    logic       rx_valid, rx_ovr, rx_ie;
    logic [7:0] rx_byte;

`ifdef BUS_UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t     rx_state_q, rx_state_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0] rx_clk_q, rx_clk_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ie_q;
    logic          rd_data, rd_status;

    assign rd_data   = rd_en && (off == 2'd0);
    assign rd_status = rd_en && (off == 2'd1);

    // Bus clears are applied first so a byte landing on the same edge wins.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_clk_d   = rx_clk_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        if (rd_data)   rx_valid_d = 1'b0;
        if (rd_status) rx_ovr_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_clk_d   = '0;
                end
            end
            RX_START: begin
                if (rx_clk_q == HALF_LAST) begin
                    rx_clk_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_clk_d = rx_clk_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_clk_q == BIT_LAST) begin
                    rx_clk_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_clk_d = rx_clk_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_clk_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) begin
                        if (!rx_valid_q || rd_data) begin
                            rx_byte_d  = rx_sh_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_ovr_d = 1'b1;
                        end
                    end
                end else begin
                    rx_clk_d = rx_clk_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_clk_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ie_q    <= 1'b0;
        end else begin
            rx_s1_q    <= i_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_clk_q   <= rx_clk_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            if (wr_en && (off == 2'd2)) rx_ie_q <= bus.i_wdata[1];
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_ovr   = rx_ovr_q;
    assign rx_ie    = rx_ie_q;
    assign rx_byte  = rx_byte_q;
`else
    logic rx_unused;
    assign rx_unused = i_rxd;
    assign rx_valid  = 1'b0;
    assign rx_ovr    = 1'b0;
    assign rx_ie     = 1'b0;
    assign rx_byte   = '0;
`endif

    logic [7:0] rdata_q, rdata_d;
    logic       hit_q;

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (off)
                2'd0:    rdata_d = rx_byte;
                2'd1:    rdata_d = {3'b000, rx_ovr, rx_valid, tx_busy, tx_empty, tx_full};
                2'd2:    rdata_d = {6'b000000, rx_ie, tx_ie_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            hit_q   <= sel;
        end
    end

    assign bus.o_rdata = rdata_q;
    assign bus.o_hit   = hit_q;
    assign o_txd       = txd_q;
    assign o_irq       = (tx_ie_q && tx_empty && !tx_busy) || (rx_ie && rx_valid);
endmodule
